// File: rtl/bpf_mc.sv
// bpf_mc: resolves up to LANES committed branches per cycle, raises a registered
// front-end redirect, and queues BPU training updates for a downstream consumer.
module bpf_mc #(
  parameter int LANES  = 2,
  parameter int QDEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                csr_flush_i,
  input  logic [31:0]         csr_target_i,
  input  logic                stall_i,
  input  logic [LANES-1:0]    valid_i,
  input  logic [LANES*32-1:0] pc_i,
  input  logic [LANES*32-1:0] rj_i,
  input  logic [LANES*32-1:0] rd_i,
  input  logic [LANES*26-1:0] inst_i,
  input  logic [LANES*2-1:0]  branch_type_i,
  input  logic [LANES*3-1:0]  cmp_type_i,
  input  logic [LANES-1:0]    link_i,
  input  logic [LANES*30-1:0] pred_npc_i,
  output logic [LANES*32-1:0] pc_link_o,
  output logic                flush_o,
  output logic [29:0]         redirect_o,
  output logic                upd_valid_o,
  input  logic                upd_ready_i,
  output logic [29:0]         upd_pc_o,
  output logic [29:0]         upd_target_o,
  output logic                upd_taken_o,
  output logic                upd_mispred_o,
  output logic [1:0]          upd_br_type_o,
  output logic [15:0]         drop_cnt_o
);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W = $clog2(QDEPTH) + 1;

  typedef struct packed {
    logic [29:0] pc;
    logic [29:0] target;
    logic        taken;
    logic        mispred;
    logic [1:0]  br_type;
  } entry_t;

  entry_t           mem_q [QDEPTH];
  entry_t           mem_d [QDEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, widx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [15:0]      drop_q, drop_d;
  logic             flush_q, flush_d;
  logic [29:0]      redirect_q, redirect_d;

  logic [29:0]      lane_tgt [LANES];
  logic [29:0]      lane_pc  [LANES];
  logic [1:0]       lane_type [LANES];
  logic [LANES-1:0] lane_taken, lane_live, lane_mis;

  logic        unused_csr;
  assign unused_csr = ^csr_target_i[1:0];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [31:0] pc, rj, rd, off16, off26, tgt;
    logic [25:0] inst;
    logic [1:0]  bt, ty;
    logic        cond, taken;
    logic        unused_lane;

    assign pc    = pc_i[g*32 +: 32];
    assign rj    = rj_i[g*32 +: 32];
    assign rd    = rd_i[g*32 +: 32];
    assign inst  = inst_i[g*26 +: 26];
    assign bt    = branch_type_i[g*2 +: 2];
    assign off16 = {{14{inst[25]}}, inst[25:10], 2'b00};
    assign off26 = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};

    always_comb begin
      case (cmp_type_i[g*3 +: 3])
        3'd0:    cond = (rj == rd);
        3'd1:    cond = (rj != rd);
        3'd2:    cond = ($signed(rj) <  $signed(rd));
        3'd3:    cond = ($signed(rj) >  $signed(rd));
        3'd4:    cond = ($signed(rj) <= $signed(rd));
        3'd5:    cond = ($signed(rj) >= $signed(rd));
        3'd6:    cond = (rj < rd);
        default: cond = (rj >= rd);
      endcase
    end

    always_comb begin
      taken = 1'b0;
      tgt   = pc + 32'd4;
      case (bt)
        2'd1: if (cond) begin
          taken = 1'b1;
          tgt   = pc + off16;
        end
        2'd2: begin
          taken = 1'b1;
          tgt   = pc + off26;
        end
        2'd3: begin
          taken = 1'b1;
          tgt   = rj + off16;
        end
        default: ;
      endcase
    end

    // CALL outranks RETURN so a jirl that both links and reads ra trains as a call
    always_comb begin
      if ((bt == 2'd3 && inst[4:0] == 5'd1) || link_i[g])           ty = 2'd2;
      else if (bt == 2'd3 && inst[9:5] == 5'd1 && inst[25:10] == '0) ty = 2'd3;
      else if (bt[1])                                                ty = 2'd1;
      else                                                           ty = 2'd0;
    end

    assign unused_lane             = ^tgt[1:0];
    assign lane_tgt[g]             = tgt[31:2];
    assign lane_pc[g]              = pc[31:2];
    assign lane_type[g]            = ty;
    assign lane_taken[g]           = taken;
    assign lane_live[g]            = valid_i[g] & ~stall_i & ~csr_flush_i & ~flush_q;
    assign lane_mis[g]             = lane_live[g] & (pred_npc_i[g*30 +: 30] != tgt[31:2]);
    assign pc_link_o[g*32 +: 32]   = pc + 32'd4;
  end

  int          nreq, nwr, free_slots, dsum;
  logic        found, deq;
  logic [29:0] sel_tgt;

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    redirect_d = redirect_q;
    flush_d    = 1'b0;
    found      = 1'b0;
    sel_tgt    = '0;
    widx       = '0;
    nreq       = 0;
    nwr        = 0;
    free_slots = QDEPTH - int'(cnt_q);
    deq        = upd_valid_o && upd_ready_i;

    // Walk oldest-first; stopping at the first mispredict squashes younger lanes
    for (int i = 0; i < LANES; i++) begin
      if (lane_live[i] && !found) begin
        if (branch_type_i[i*2 +: 2] != 2'd0) begin
          if (nreq < free_slots) begin
            widx                 = PTR_W'((int'(wr_ptr_q) + nreq) % QDEPTH);
            mem_d[widx].pc       = lane_pc[i];
            mem_d[widx].target   = lane_tgt[i];
            mem_d[widx].taken    = lane_taken[i];
            mem_d[widx].mispred  = lane_mis[i];
            mem_d[widx].br_type  = lane_type[i];
            nwr++;
          end
          nreq++;
        end
        if (lane_mis[i]) begin
          found   = 1'b1;
          sel_tgt = lane_tgt[i];
        end
      end
    end

    if (csr_flush_i) begin
      flush_d    = 1'b1;
      redirect_d = csr_target_i[31:2];
    end else if (found) begin
      flush_d    = 1'b1;
      redirect_d = sel_tgt;
    end

    wr_ptr_d = PTR_W'((int'(wr_ptr_q) + nwr) % QDEPTH);
    if (deq) rd_ptr_d = PTR_W'((int'(rd_ptr_q) + 1) % QDEPTH);
    cnt_d  = CNT_W'(int'(cnt_q) + nwr - (deq ? 1 : 0));
    dsum   = int'(drop_q) + (nreq - nwr);
    drop_d = (dsum > 32'hFFFF) ? 16'hFFFF : 16'(dsum);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q      <= '{default: '0};
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      drop_q     <= '0;
      flush_q    <= 1'b0;
      redirect_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
    end
  end

  assign flush_o       = flush_q;
  assign redirect_o    = redirect_q;
  assign drop_cnt_o    = drop_q;
  assign upd_valid_o   = (cnt_q != '0);
  assign upd_pc_o      = mem_q[rd_ptr_q].pc;
  assign upd_target_o  = mem_q[rd_ptr_q].target;
  assign upd_taken_o   = mem_q[rd_ptr_q].taken;
  assign upd_mispred_o = mem_q[rd_ptr_q].mispred;
  assign upd_br_type_o = mem_q[rd_ptr_q].br_type;
endmodule

// File: tb/tb_bpf_mc.sv
// Bench for bpf_mc: directed scenarios followed by random traffic, all checked
// against a queue-based reference model of branch resolution and update queueing.
module tb_bpf_mc;
  localparam int L  = 2;
  localparam int QD = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          csr_flush_i, stall_i, upd_ready_i;
  logic [31:0]   csr_target_i;
  logic [L-1:0]  valid_i, link_i;
  logic [L*32-1:0] pc_i, rj_i, rd_i, pc_link_o;
  logic [L*26-1:0] inst_i;
  logic [L*2-1:0]  branch_type_i;
  logic [L*3-1:0]  cmp_type_i;
  logic [L*30-1:0] pred_npc_i;
  logic          flush_o, upd_valid_o, upd_taken_o, upd_mispred_o;
  logic [29:0]   redirect_o, upd_pc_o, upd_target_o;
  logic [1:0]    upd_br_type_o;
  logic [15:0]   drop_cnt_o;

  logic [31:0] t_pc [L], t_rj [L], t_rd [L];
  logic [25:0] t_inst [L];
  logic [1:0]  t_bt [L];
  logic [2:0]  t_ct [L];
  logic [29:0] t_pred [L];
  logic        t_valid [L], t_link [L];

  for (genvar g = 0; g < L; g++) begin : g_pack
    assign valid_i[g]               = t_valid[g];
    assign link_i[g]                = t_link[g];
    assign pc_i[g*32 +: 32]         = t_pc[g];
    assign rj_i[g*32 +: 32]         = t_rj[g];
    assign rd_i[g*32 +: 32]         = t_rd[g];
    assign inst_i[g*26 +: 26]       = t_inst[g];
    assign branch_type_i[g*2 +: 2]  = t_bt[g];
    assign cmp_type_i[g*3 +: 3]     = t_ct[g];
    assign pred_npc_i[g*30 +: 30]   = t_pred[g];
  end

  bpf_mc #(.LANES(L), .QDEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .csr_flush_i(csr_flush_i), .csr_target_i(csr_target_i),
    .stall_i(stall_i), .valid_i(valid_i), .pc_i(pc_i), .rj_i(rj_i), .rd_i(rd_i),
    .inst_i(inst_i), .branch_type_i(branch_type_i), .cmp_type_i(cmp_type_i),
    .link_i(link_i), .pred_npc_i(pred_npc_i), .pc_link_o(pc_link_o),
    .flush_o(flush_o), .redirect_o(redirect_o), .upd_valid_o(upd_valid_o),
    .upd_ready_i(upd_ready_i), .upd_pc_o(upd_pc_o), .upd_target_o(upd_target_o),
    .upd_taken_o(upd_taken_o), .upd_mispred_o(upd_mispred_o),
    .upd_br_type_o(upd_br_type_o), .drop_cnt_o(drop_cnt_o)
  );

  typedef struct {
    logic [29:0] pc;
    logic [29:0] tgt;
    logic        tk;
    logic        mis;
    logic [1:0]  ty;
  } ent_t;

  ent_t        mq[$];
  logic        m_flush;
  logic [29:0] m_redir;
  int          m_drop;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit cmp_ok(input logic [2:0] ct, input logic [31:0] a, input logic [31:0] b);
    int     sa, sb;
    longint ua, ub;
    sa = a; sb = b; ua = longint'(a); ub = longint'(b);
    case (ct)
      3'd0: return sa == sb;
      3'd1: return sa != sb;
      3'd2: return sa < sb;
      3'd3: return sa > sb;
      3'd4: return sa <= sb;
      3'd5: return sa >= sb;
      3'd6: return ua < ub;
      default: return ua >= ub;
    endcase
  endfunction

  function automatic void eval_lane(input int i, output logic [31:0] tgt,
                                    output logic tk, output logic [1:0] ty);
    int          o16, o26;
    logic [15:0] f16;
    logic [25:0] f26;
    f16 = t_inst[i][25:10];
    f26 = {t_inst[i][9:0], t_inst[i][25:10]};
    o16 = int'($signed(f16)) * 4;
    o26 = int'($signed(f26)) * 4;
    tk  = 1'b0;
    tgt = t_pc[i] + 32'd4;
    if (t_bt[i] == 2'd1 && cmp_ok(t_ct[i], t_rj[i], t_rd[i])) begin
      tk = 1'b1; tgt = 32'(t_pc[i] + o16);
    end else if (t_bt[i] == 2'd2) begin
      tk = 1'b1; tgt = 32'(t_pc[i] + o26);
    end else if (t_bt[i] == 2'd3) begin
      tk = 1'b1; tgt = 32'(t_rj[i] + o16);
    end
    if ((t_bt[i] == 2'd3 && t_inst[i][4:0] == 5'd1) || t_link[i]) ty = 2'd2;
    else if (t_bt[i] == 2'd3 && t_inst[i][9:5] == 5'd1 && o16 == 0) ty = 2'd3;
    else if (t_bt[i] >= 2'd2) ty = 2'd1;
    else ty = 2'd0;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_flush = 1'b0;
    m_redir = '0;
    m_drop  = 0;
  endtask

  task automatic model_step();
    logic [31:0] tg;
    logic        tk, found;
    logic [1:0]  ty;
    logic [29:0] ktg;
    ent_t        e;
    ent_t        add[$];
    int          room, nreq;
    bit          live_ok;
    live_ok = !stall_i && !csr_flush_i && !m_flush;
    room = QD - mq.size();
    nreq = 0; found = 1'b0; ktg = '0;
    for (int i = 0; i < L; i++) begin
      if (live_ok && t_valid[i] && !found) begin
        eval_lane(i, tg, tk, ty);
        e = '{t_pc[i][31:2], tg[31:2], tk, (t_pred[i] != tg[31:2]), ty};
        if (t_bt[i] != 2'd0) begin
          if (nreq < room) add.push_back(e);
          nreq++;
        end
        if (e.mis) begin found = 1'b1; ktg = tg[31:2]; end
      end
    end
    if (mq.size() != 0 && upd_ready_i) void'(mq.pop_front());
    foreach (add[j]) mq.push_back(add[j]);
    m_drop = m_drop + (nreq - add.size());
    if (m_drop > 65535) m_drop = 65535;
    m_flush = csr_flush_i || found;
    if (csr_flush_i) m_redir = csr_target_i[31:2];
    else if (found) m_redir = ktg;
  endtask

  task automatic compare_all();
    check("flush", flush_o, m_flush);
    check("redirect", redirect_o, m_redir);
    check("upd_valid", upd_valid_o, mq.size() != 0);
    check("drop_cnt", drop_cnt_o, m_drop);
    if (mq.size() != 0)
      check("head", {upd_pc_o, upd_target_o, upd_taken_o, upd_mispred_o, upd_br_type_o},
            {mq[0].pc, mq[0].tgt, mq[0].tk, mq[0].mis, mq[0].ty});
  endtask

  task automatic cycle();
    #1;
    for (int i = 0; i < L; i++) check("pc_link", pc_link_o[i*32 +: 32], t_pc[i] + 32'd4);
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic clear_lanes();
    for (int i = 0; i < L; i++) begin
      t_valid[i] = 1'b0; t_link[i] = 1'b0; t_pc[i] = '0; t_rj[i] = '0; t_rd[i] = '0;
      t_inst[i] = '0; t_bt[i] = '0; t_ct[i] = '0; t_pred[i] = '0;
    end
  endtask

  task automatic set_lane(input int i, input logic [31:0] pc, input logic [31:0] rj,
                          input logic [31:0] rd, input logic [25:0] inst, input logic [1:0] bt,
                          input logic [2:0] ct, input logic lk, input logic [29:0] pred);
    t_valid[i] = 1'b1; t_pc[i] = pc; t_rj[i] = rj; t_rd[i] = rd; t_inst[i] = inst;
    t_bt[i] = bt; t_ct[i] = ct; t_link[i] = lk; t_pred[i] = pred;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0: return 32'd0;
      1: return 32'd7;
      2: return 32'hFFFF_FFF9;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  task automatic rand_lane(input int i);
    logic [31:0] tg;
    logic        tk;
    logic [1:0]  ty;
    t_valid[i] = ($urandom_range(0, 3) != 0);
    t_pc[i]    = $urandom & 32'hFFFF_FFFC;
    t_rj[i]    = pick_val();
    t_rd[i]    = pick_val();
    t_inst[i]  = 26'($urandom);
    if ($urandom_range(0, 7) == 0) begin
      t_inst[i][25:10] = '0;
      t_inst[i][9:5]   = 5'd1;
    end
    t_bt[i]   = 2'($urandom_range(0, 3));
    t_ct[i]   = 3'($urandom_range(0, 7));
    t_link[i] = ($urandom_range(0, 3) == 0);
    eval_lane(i, tg, tk, ty);
    t_pred[i] = ($urandom_range(0, 9) < 7) ? tg[31:2] : 30'($urandom);
  endtask

  initial begin
    clear_lanes();
    csr_flush_i = 1'b0; csr_target_i = '0; stall_i = 1'b0; upd_ready_i = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_flush", flush_o, 1'b0);
    check("rst_redirect", redirect_o, 30'h0);
    check("rst_upd_valid", upd_valid_o, 1'b0);
    check("rst_drop", drop_cnt_o, 16'h0);
    @(negedge clk) rst_n = 1'b1;

    // beq taken, predicted fall-through
    set_lane(0, 32'h1000, 32'd5, 32'd5, 26'h1000, 2'd1, 3'd0, 1'b0, 30'h401);
    cycle();
    check("beq_flush", flush_o, 1'b1);
    check("beq_redirect", redirect_o, 30'h404);
    check("beq_entry", {upd_valid_o, upd_taken_o, upd_mispred_o}, 3'b111);
    clear_lanes(); upd_ready_i = 1'b1;
    repeat (2) cycle();

    // younger jirl squashed behind a mispredicting lane 0
    upd_ready_i = 1'b0;
    set_lane(0, 32'h1000, 32'd5, 32'd5, 26'h1000, 2'd1, 3'd0, 1'b0, 30'h401);
    set_lane(1, 32'h1004, 32'h2000, 32'd0, 26'h0, 2'd3, 3'd0, 1'b0, 30'h0);
    cycle();
    check("squash_redirect", redirect_o, 30'h404);
    clear_lanes(); upd_ready_i = 1'b1;
    cycle();
    check("squash_one_entry", upd_valid_o, 1'b0);
    cycle();

    // csr redirect wins and blocks enqueue
    upd_ready_i = 1'b0;
    set_lane(0, 32'h1000, 32'd5, 32'd5, 26'h1000, 2'd1, 3'd0, 1'b0, 30'h401);
    csr_flush_i = 1'b1; csr_target_i = 32'h1C00_0000;
    cycle();
    check("csr_flush", flush_o, 1'b1);
    check("csr_redirect", redirect_o, 30'h0700_0000);
    check("csr_no_enq", upd_valid_o, 1'b0);
    csr_flush_i = 1'b0; clear_lanes();
    cycle();

    // overfill with correctly predicted not-taken branches
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < L; j++)
        set_lane(j, 32'h2000 + 32'(8*c + 4*j), 32'd0, 32'd0, 26'h40, 2'd1, 3'd1, 1'b0,
                 30'((32'h2004 + 32'(8*c + 4*j)) >> 2));
      cycle();
    end
    check("full_drop", drop_cnt_o, 16'd2);
    check("full_valid", upd_valid_o, 1'b1);
    check("full_head", {upd_pc_o, upd_taken_o, upd_mispred_o}, {30'h800, 2'b00});
    clear_lanes(); upd_ready_i = 1'b1;
    cycle();
    upd_ready_i = 1'b0;

    // asynchronous reset with three entries pending
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", upd_valid_o, 1'b0);
    check("async_rst_drop", drop_cnt_o, 16'h0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    // jirl return, bl call, GEU equal operands
    set_lane(0, 32'h3000, 32'h4000, 32'd0, 26'h20, 2'd3, 3'd0, 1'b0, 30'h1000);
    cycle();
    check("ret_type", {upd_valid_o, upd_br_type_o, upd_taken_o}, {1'b1, 2'd3, 1'b1});
    clear_lanes(); upd_ready_i = 1'b1; cycle(); upd_ready_i = 1'b0;
    set_lane(0, 32'h3000, 32'd0, 32'd0, 26'h400, 2'd2, 3'd0, 1'b1, 30'hC01);
    cycle();
    check("call_type", {upd_valid_o, upd_br_type_o, upd_mispred_o}, {1'b1, 2'd2, 1'b0});
    clear_lanes(); upd_ready_i = 1'b1; cycle(); upd_ready_i = 1'b0;
    set_lane(0, 32'h3000, 32'd7, 32'd7, 26'h800, 2'd1, 3'd7, 1'b0, 30'hC02);
    cycle();
    check("geu_taken", {upd_valid_o, upd_taken_o, upd_target_o}, {2'b11, 30'hC02});
    clear_lanes(); upd_ready_i = 1'b1; cycle();

    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < L; i++) rand_lane(i);
      stall_i      = ($urandom_range(0, 9) == 0);
      csr_flush_i  = ($urandom_range(0, 19) == 0);
      csr_target_i = $urandom;
      upd_ready_i  = ($urandom_range(0, 2) == 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bpf_mc.md
BPF_MC -- requirements
Module: bpf_mc

Interface
REQ-001 Parameter LANES, default 2, range 1..4: branch-resolution lanes per cycle; lane 0 is oldest.
REQ-002 Parameter QDEPTH, default 4, power of two >= LANES: update-queue entries.
REQ-003 clk  input  1  clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 csr_flush_i  input  1  exception/ertn redirect request.
REQ-006 csr_target_i  input  32  redirect target for csr_flush_i.
REQ-007 stall_i  input  1  pipeline stall; inputs are not consumed.
REQ-008 valid_i  input  LANES  lane carries a committed-path instruction.
REQ-009 pc_i, rj_i, rd_i  input  LANES*32 each  per-lane PC and operand values.
REQ-010 inst_i  input  LANES*26  per-lane instruction bits [25:0].
REQ-011 branch_type_i  input  LANES*2  0 invalid, 1 conditional, 2 immediate (b/bl), 3 indirect (jirl).
REQ-012 cmp_type_i  input  LANES*3  0 EQ, 1 NE, 2 LT, 3 GT, 4 LE, 5 GE, 6 LTU, 7 GEU.
REQ-013 link_i  input  LANES  instruction writes a link register.
REQ-014 pred_npc_i  input  LANES*30  predicted next PC [31:2].
REQ-015 pc_link_o  output  LANES*32  per-lane pc_i+4, combinational.
REQ-016 flush_o  output  1  registered front-end redirect pulse.
REQ-017 redirect_o  output  30  registered redirect target [31:2].
REQ-018 upd_valid_o / upd_ready_i  output / input  1 / 1  BPU update handshake.
REQ-019 upd_pc_o, upd_target_o  output  30 each  queue head: branch PC[31:2], resolved target[31:2].
REQ-020 upd_taken_o, upd_mispred_o  output  1 each  queue head: resolved direction, misprediction flag.
REQ-021 upd_br_type_o  output  2  0 PC_RELATIVE, 1 ABSOLUTE, 2 CALL, 3 RETURN.
REQ-022 drop_cnt_o  output  16  saturating count of updates dropped for lack of space.

Function
REQ-023 Per-lane offsets: off16 = sext(inst[25:10])<<2; off26 = sext({inst[9:0],inst[25:10]})<<2; all sums are modulo 2^32.
REQ-024 Per-lane target: immediate pc+off26; indirect rj+off16; conditional pc+off16 if taken, else pc+4; invalid pc+4.
REQ-025 Taken: conditional per cmp_type (signed for LT/GT/LE/GE, unsigned for LTU, and rj>=rd unsigned for GEU); types 2/3 are always taken; invalid is never taken.
REQ-026 br_type priority: CALL if (indirect and rd index==1) or link_i; else RETURN if indirect, rj index==1 and off16==0; else ABSOLUTE for types 2/3; else PC_RELATIVE.
REQ-027 A lane is live when valid_i=1, stall_i=0, csr_flush_i=0 and flush_o=0 in that cycle; lanes arriving during a flush_o cycle are wrong-path and ignored.
REQ-028 A lane mispredicts when it is live and pred_npc_i != target[31:2].
REQ-029 The oldest mispredicting lane k is selected; lanes with index > k are squashed and have no effect.
REQ-030 On the next edge: flush_o=1 if csr_flush_i or any misprediction; redirect_o=csr_target_i[31:2] if csr_flush_i (priority), else target_k[31:2]; otherwise flush_o=0 and redirect_o holds its value.
REQ-031 Enqueue: every live, unsquashed lane with branch_type!=0 is written in ascending lane order, with upd_mispred set only for lane k.
REQ-032 If free space < requested entries, the oldest entries that fit are written, the rest are dropped, and drop_cnt_o is incremented by the number dropped, saturating at 0xFFFF.
REQ-033 Free space is computed before the same-cycle dequeue; a simultaneous dequeue does not create room that cycle.
REQ-034 Dequeue occurs when upd_valid_o and upd_ready_i are both 1; upd_valid_o = (count != 0); head fields are held stable while not accepted.
REQ-035 Read/write pointers wrap modulo QDEPTH; count width is log2(QDEPTH)+1.
REQ-036 csr_flush_i neither clears the queue nor blocks dequeue.

Reset
REQ-037 While rst_n=0: flush_o=0, redirect_o=0, queue empty (upd_valid_o=0), pointers=0, drop_cnt_o=0; head data outputs are don't-care while upd_valid_o=0.
REQ-038 Reset asserted mid-operation discards all queued entries immediately; the first edge after deassertion behaves as a fresh start.

Verification
REQ-039 LANES=2: lane0 beq, pc=0x1000, rj=rd=5, inst[25:10]=4, pred_npc=0x1004>>2 -> next cycle flush_o=1, redirect_o=0x1010>>2; one entry with taken=1, mispred=1.
REQ-040 Lane0 mispredicts, lane1 is a valid jirl -> only lane0 is enqueued; lane1 is squashed; redirect_o comes from lane0.
REQ-041 csr_flush_i=1, csr_target_i=0x1C000000, with a mispredicting lane -> flush_o=1, redirect_o=0x07000000, no enqueue.
REQ-042 QDEPTH=4, upd_ready_i=0, 3 cycles of 2 correctly predicted branches -> count reaches 4, drop_cnt_o=2; upd_valid_o stays high and head is unchanged.
REQ-043 jirl rd=0, rj=1, off16=0 -> br_type=RETURN; bl -> CALL; GEU with rj=rd=7 -> taken=1.
REQ-044 rst_n asserted low with 3 entries queued -> upd_valid_o=0 and drop_cnt_o=0 immediately, without waiting for a clock edge.
